// File: rtl/gpr_pkg.sv
// Shared constants and write-port arbitration helper for the GPR scoreboard.
package gpr_pkg;

    localparam int unsigned DW_DEF = 32;
    localparam int unsigned AW_DEF = 5;
    // Upper bound on write ports accepted by win_idx.
    localparam int unsigned MAX_NW = 32;

    // Index of the highest set bit in a per-port hit vector; the caller
    // gates the result with |hit.
    function automatic int unsigned win_idx(input logic [MAX_NW-1:0] hit);
        int unsigned idx;
        idx = 0;
        for (int unsigned k = 0; k < MAX_NW; k++) begin
            if (hit[k]) idx = k;
        end
        return idx;
    endfunction

endpackage

// File: rtl/gpr_sb_rport.sv
// Single read port: zero-register check, priority write bypass, busy qualify.
module gpr_sb_rport
    import gpr_pkg::*;
#(
    parameter int unsigned DW       = DW_DEF,
    parameter int unsigned AW       = AW_DEF,
    parameter int unsigned NW       = 2,
    parameter bit          ZERO_REG = 1'b1
) (
    input  logic [AW-1:0]    ra,
    input  logic [NW-1:0]    eff,
    input  logic [NW*AW-1:0] wa,
    input  logic [NW*DW-1:0] wd,
    input  logic [DW-1:0]    g_data,
    input  logic             g_busy,
    output logic [DW-1:0]    rd,
    output logic             rbusy
);

    localparam int unsigned IW = (NW > 1) ? $clog2(NW) : 1;

    logic [AW-1:0] wa_arr [NW];
    logic [DW-1:0] wd_arr [NW];
    logic [NW-1:0] hit;

    for (genvar k = 0; k < NW; k++) begin : g_unpack
        assign wa_arr[k] = wa[k*AW +: AW];
        assign wd_arr[k] = wd[k*DW +: DW];
    end

    // Effective writes that target this port's address.
    always_comb begin
        hit = '0;
        for (int unsigned k = 0; k < NW; k++) begin
            hit[IW'(k)] = eff[IW'(k)] && (wa_arr[IW'(k)] == ra);
        end
    end

    // Output select: zero register, then bypass, then stored state.
    always_comb begin
        rd    = g_data;
        rbusy = g_busy;
        if (ZERO_REG && ra == '0) begin
            rd    = '0;
            rbusy = 1'b0;
        end else if (|hit) begin
            rd    = wd_arr[IW'(win_idx(MAX_NW'(hit)))];
            rbusy = 1'b0;
        end
    end

endmodule

// File: rtl/gpr_sb.sv
// Multi-port general-purpose register file with write-pending scoreboard.
module gpr_sb
    import gpr_pkg::*;
#(
    parameter int unsigned DW       = DW_DEF,
    parameter int unsigned AW       = AW_DEF,
    parameter int unsigned NR       = 2,
    parameter int unsigned NW       = 2,
    parameter bit          ZERO_REG = 1'b1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [NR*AW-1:0]    ra,
    output logic [NR*DW-1:0]    rd,
    output logic [NR-1:0]       rbusy,
    input  logic [NW-1:0]       we,
    input  logic [NW*AW-1:0]    wa,
    input  logic [NW*DW-1:0]    wd,
    input  logic                set_en,
    input  logic [AW-1:0]       set_addr,
    input  logic                flush,
    output logic [(2**AW)-1:0]  busy_vec
);

    localparam int unsigned DEPTH = 2 ** AW;
    localparam int unsigned IW    = (NW > 1) ? $clog2(NW) : 1;

    logic [DW-1:0]    g        [DEPTH];
    logic [DEPTH-1:0] busy;
    logic [DEPTH-1:0] busy_nxt;
    logic [NW-1:0]    eff;
    logic [NW-1:0]    wr_hit   [DEPTH];
    logic [DW-1:0]    wr_data  [DEPTH];
    logic [AW-1:0]    wa_arr   [NW];
    logic [DW-1:0]    wd_arr   [NW];

    for (genvar k = 0; k < NW; k++) begin : g_unpack
        assign wa_arr[k] = wa[k*AW +: AW];
        assign wd_arr[k] = wd[k*DW +: DW];
    end

    // Qualify write enables: reset and register-0 writes are dropped.
    always_comb begin
        eff = '0;
        for (int unsigned k = 0; k < NW; k++) begin
            eff[IW'(k)] = we[IW'(k)] && !reset
                          && !(ZERO_REG && wa_arr[IW'(k)] == '0);
        end
    end

    // Per-register write hits and the winning (highest-index) data.
    always_comb begin
        for (int unsigned a = 0; a < DEPTH; a++) begin
            wr_hit[AW'(a)]  = '0;
            for (int unsigned k = 0; k < NW; k++) begin
                wr_hit[AW'(a)][IW'(k)] = eff[IW'(k)] && (wa_arr[IW'(k)] == AW'(a));
            end
            wr_data[AW'(a)] = wd_arr[IW'(win_idx(MAX_NW'(wr_hit[AW'(a)])))];
        end
    end

    // Next busy state: flush beats set; set beats a same-cycle write clear.
    always_comb begin
        busy_nxt = busy;
        if (flush) begin
            busy_nxt = '0;
        end else begin
            for (int unsigned a = 0; a < DEPTH; a++) begin
                if (|wr_hit[AW'(a)]) busy_nxt[AW'(a)] = 1'b0;
            end
            if (set_en && !(ZERO_REG && set_addr == '0)) busy_nxt[set_addr] = 1'b1;
        end
    end

    // Register array and scoreboard state.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int unsigned a = 0; a < DEPTH; a++) g[AW'(a)] <= '0;
            busy <= '0;
        end else begin
            for (int unsigned a = 0; a < DEPTH; a++) begin
                if (|wr_hit[AW'(a)]) g[AW'(a)] <= wr_data[AW'(a)];
            end
            busy <= busy_nxt;
        end
    end

    assign busy_vec = ZERO_REG ? {busy[DEPTH-1:1], 1'b0} : busy;

    for (genvar i = 0; i < NR; i++) begin : g_rport
        logic [AW-1:0] ra_i;
        assign ra_i = ra[i*AW +: AW];

        gpr_sb_rport #(
            .DW       (DW),
            .AW       (AW),
            .NW       (NW),
            .ZERO_REG (ZERO_REG)
        ) u_rport (
            .ra     (ra_i),
            .eff    (eff),
            .wa     (wa),
            .wd     (wd),
            .g_data (g[ra_i]),
            .g_busy (busy[ra_i]),
            .rd     (rd[i*DW +: DW]),
            .rbusy  (rbusy[i])
        );
    end

endmodule

// File: tb/tb_gpr_sb.sv
// Directed scoreboard bench for gpr_sb with default parameters.
module tb_gpr_sb;

    localparam int unsigned DW = 32;
    localparam int unsigned AW = 5;

    logic          clk = 1'b0;
    logic          reset;
    logic [2*AW-1:0] ra;
    logic [2*DW-1:0] rd;
    logic [1:0]    rbusy;
    logic [1:0]    we;
    logic [2*AW-1:0] wa;
    logic [2*DW-1:0] wd;
    logic          set_en;
    logic [AW-1:0] set_addr;
    logic          flush;
    logic [31:0]   busy_vec;

    typedef struct {
        string       tag;
        logic [31:0] val;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    gpr_sb #(
        .DW       (DW),
        .AW       (AW),
        .NR       (2),
        .NW       (2),
        .ZERO_REG (1'b1)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .ra       (ra),
        .rd       (rd),
        .rbusy    (rbusy),
        .we       (we),
        .wa       (wa),
        .wd       (wd),
        .set_en   (set_en),
        .set_addr (set_addr),
        .flush    (flush),
        .busy_vec (busy_vec)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input string tag, input logic [31:0] val);
        exp_t e;
        e.tag = tag;
        e.val = val;
        sb.push_back(e);
    endtask

    task automatic check(input logic [31:0] obs);
        exp_t e;
        n_cmp++;
        if (sb.size() == 0) begin
            n_bad++;
            $error("FAIL sb_empty: observed %h with no expectation queued", obs);
        end else begin
            e = sb.pop_front();
            assert (obs === e.val)
            else begin
                n_bad++;
                $error("FAIL %s: observed %h expected %h", e.tag, obs, e.val);
            end
        end
    endtask

    function automatic logic [31:0] rd0();
        return rd[0 +: DW];
    endfunction

    function automatic logic [31:0] rd1();
        return rd[DW +: DW];
    endfunction

    task automatic idle();
        we = '0; set_en = 1'b0; flush = 1'b0; reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1; ra = '0; we = '0; wa = '0; wd = '0;
        set_en = 1'b0; set_addr = '0; flush = 1'b0;
        tick();
        idle();

        // Reset state
        ra = {5'd31, 5'd3}; #1;
        push("rst_busy_vec", 32'h0);          check(busy_vec);
        push("rst_rd0_r3", 32'h0);            check(rd0());
        push("rst_rd1_r31", 32'h0);           check(rd1());
        push("rst_rbusy", 32'h0);             check({30'd0, rbusy});

        // Write r3, read before and after
        we = 2'b01; wa = {5'd0, 5'd3}; wd = {32'h0, 32'hDEADBEEF};
        ra = {5'd5, 5'd5}; #1;
        push("prewrite_r5", 32'h0);           check(rd0());
        tick(); idle();
        ra = {5'd0, 5'd3}; #1;
        push("write_r3", 32'hDEADBEEF);       check(rd0());

        // Two ports same address: port 1 wins, bypass and stored
        we = 2'b11; wa = {5'd7, 5'd7}; wd = {32'h22, 32'h11};
        ra = {5'd7, 5'd3}; #1;
        push("bypass_prio", 32'h22);          check(rd1());
        push("bypass_other_port", 32'hDEADBEEF); check(rd0());
        tick(); idle();
        ra = {5'd0, 5'd7}; #1;
        push("stored_prio_r7", 32'h22);       check(rd0());

        // Zero register is never written nor busy
        we = 2'b10; wa = {5'd0, 5'd0}; wd = {32'hFFFF, 32'h0};
        set_en = 1'b1; set_addr = 5'd0; ra = {5'd0, 5'd0}; #1;
        push("r0_bypass", 32'h0);             check(rd0());
        push("r0_rbusy", 32'h0);              check({31'd0, rbusy[0]});
        tick(); idle(); #1;
        push("r0_after", 32'h0);              check(rd0());
        push("r0_busy_vec", 32'h0);           check(busy_vec);

        // Scoreboard set then clear by write
        set_en = 1'b1; set_addr = 5'd9;
        tick(); idle();
        ra = {5'd9, 5'd0}; #1;
        push("set9_busy_vec", 32'h0000_0200); check(busy_vec);
        push("set9_rbusy", 32'h1);            check({31'd0, rbusy[1]});
        we = 2'b01; wa = {5'd0, 5'd9}; wd = {32'h0, 32'h5}; #1;
        push("clr9_rbusy_bypass", 32'h0);     check({31'd0, rbusy[1]});
        push("clr9_rd_bypass", 32'h5);        check(rd1());
        tick(); idle(); #1;
        push("clr9_busy_vec", 32'h0);         check(busy_vec);
        push("clr9_rd", 32'h5);               check(rd1());

        // Set/clear collision on r4: set wins, data written
        set_en = 1'b1; set_addr = 5'd4;
        tick(); idle();
        set_en = 1'b1; set_addr = 5'd4;
        we = 2'b01; wa = {5'd0, 5'd4}; wd = {32'h0, 32'h44};
        tick(); idle();
        ra = {5'd0, 5'd4}; #1;
        push("collide_busy_vec", 32'h0000_0010); check(busy_vec);
        push("collide_rd", 32'h44);           check(rd0());
        push("collide_rbusy", 32'h1);         check({31'd0, rbusy[0]});

        // Top register and dual distinct-address write; r31 not busy
        we = 2'b11; wa = {5'd10, 5'd31}; wd = {32'hA0A0, 32'hCAFEF00D};
        tick(); idle();
        ra = {5'd10, 5'd31}; #1;
        push("top_r31", 32'hCAFEF00D);        check(rd0());
        push("dual_r10", 32'hA0A0);           check(rd1());
        push("nonbusy_write", 32'h0000_0010); check(busy_vec);

        // Busy 2, 5, 31 then flush with simultaneous set of 6
        set_en = 1'b1; set_addr = 5'd2;  tick();
        set_addr = 5'd5;                 tick();
        set_addr = 5'd31;                tick(); idle();
        ra = {5'd0, 5'd31}; #1;
        push("multi_busy", 32'h8000_0034);    check(busy_vec);
        push("top_rbusy", 32'h1);             check({31'd0, rbusy[0]});
        flush = 1'b1; set_en = 1'b1; set_addr = 5'd6;
        tick(); idle(); #1;
        push("flush_busy_vec", 32'h0);        check(busy_vec);

        // Reset mid-operation: stored view, no bypass, then cleared
        we = 2'b01; wa = {5'd0, 5'd8}; wd = {32'h0, 32'h77};
        set_en = 1'b1; set_addr = 5'd8;
        tick(); idle();
        reset = 1'b1; we = 2'b01; wa = {5'd0, 5'd8}; wd = {32'h0, 32'hAA};
        ra = {5'd3, 5'd8}; #1;
        push("rst_nobypass_rd", 32'h77);      check(rd0());
        push("rst_stored_rbusy", 32'h1);      check({31'd0, rbusy[0]});
        tick(); idle(); #1;
        push("post_rst_r8", 32'h0);           check(rd0());
        push("post_rst_r3", 32'h0);           check(rd1());
        push("post_rst_busy", 32'h0);         check(busy_vec);

        if (sb.size() != 0) begin
            n_cmp++;
            n_bad++;
            $error("FAIL sb_leftover: observed %0d expected 0", sb.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: observed no finish expected finish");
        $fatal(1, "timeout");
    end

endmodule
